// File: rtl/rv_mem_arb_pkg.sv
// Shared types and constants for the rv_cpu memory arbiter: response kinds and MMIO addresses.
package rv_mem_arb_pkg;

   typedef enum logic [2:0] {
      RESP_NONE,
      RESP_FETCH,
      RESP_LOAD,
      RESP_STORE,
      RESP_MMIO
   } resp_kind_t;

   localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'h0010_0000;
   localparam logic [31:0] MMIO_DONE_ADDR    = 32'h0010_0004;

   // Byte offset within the word is irrelevant for MMIO decode.
   function automatic logic is_mmio_word(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:2] == base[31:2];
   endfunction

endpackage

// File: rtl/rv_mem_arb_mmio.sv
// MMIO decode for the console and test-done registers with registered one-cycle strobes.
// Only instantiated when URV_MEM_ARB_MMIO_EN is defined.
module rv_mem_arb_mmio
   import rv_mem_arb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic        store_grant_i,
   output logic        store_hit_o,
   output logic        load_hit_o,
   output logic        console_valid_o,
   output logic [7:0]  console_data_o,
   output logic        test_done_o
);

   logic       con_hit;
   logic       done_hit;
   logic       console_valid_q;
   logic [7:0] console_data_q;
   logic       test_done_q;
   logic       unused_mmio_bits;

   assign con_hit  = is_mmio_word(dm_addr_i, MMIO_CONSOLE_ADDR);
   assign done_hit = is_mmio_word(dm_addr_i, MMIO_DONE_ADDR);

   // The two MMIO words cover exactly the 0x0010_0000-0x0010_0007 load window.
   assign store_hit_o = con_hit | done_hit;
   assign load_hit_o  = con_hit | done_hit;

   assign unused_mmio_bits = ^{dm_addr_i[1:0], dm_data_s_i[31:8]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         console_valid_q <= 1'b0;
         console_data_q  <= '0;
         test_done_q     <= 1'b0;
      end else begin
         console_valid_q <= store_grant_i & con_hit;
         test_done_q     <= store_grant_i & done_hit;
         if (store_grant_i & con_hit)
            console_data_q <= dm_data_s_i[7:0];
      end
   end

   assign console_valid_o = console_valid_q;
   assign console_data_o  = console_data_q;
   assign test_done_o     = test_done_q;

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-port RAM between rv_cpu fetch and data ports; data wins unless fetch is starved.
// Optional MMIO console/test-done registers are enabled by defining URV_MEM_ARB_MMIO_EN.
module rv_mem_arbiter
   import rv_mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH       = 14,
   parameter int FETCH_STARVE_MAX = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [31:0]           im_addr_i,
   output logic [31:0]           im_data_o,
   output logic                  im_valid_o,
   input  logic [31:0]           dm_addr_i,
   input  logic [31:0]           dm_data_s_i,
   input  logic [3:0]            dm_data_select_i,
   input  logic                  dm_store_i,
   input  logic                  dm_load_i,
   output logic                  dm_ready_o,
   output logic [31:0]           dm_data_l_o,
   output logic                  dm_load_done_o,
   output logic                  dm_store_done_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic [3:0]            ram_we_o,
   input  logic [31:0]           ram_rdata_i,
   output logic                  console_valid_o,
   output logic [7:0]            console_data_o,
   output logic                  test_done_o
);

   localparam int              CW         = $clog2(FETCH_STARVE_MAX + 1);
   localparam logic [CW-1:0]   STARVE_MAX = CW'(FETCH_STARVE_MAX);

   resp_kind_t    resp_q, resp_d;
   logic [CW-1:0] starve_q, starve_d;
   logic [31:0]   im_data_q;
   logic [31:0]   dm_data_q;
   logic          starved;
   logic          data_grant;
   logic          store_grant;
   logic          mmio_store_hit;
   logic          mmio_load_hit;
   logic          unused_addr_bits;

   assign starved     = (starve_q == STARVE_MAX);
   assign data_grant  = (dm_load_i | dm_store_i) & ~starved & ~rst_i;
   assign store_grant = data_grant & dm_store_i;

   assign unused_addr_bits = ^{im_addr_i[31:ADDR_WIDTH+2], im_addr_i[1:0],
                               dm_addr_i[31:ADDR_WIDTH+2], dm_addr_i[1:0]};

`ifdef URV_MEM_ARB_MMIO_EN
   rv_mem_arb_mmio u_mmio (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .dm_addr_i       (dm_addr_i),
      .dm_data_s_i     (dm_data_s_i),
      .store_grant_i   (store_grant),
      .store_hit_o     (mmio_store_hit),
      .load_hit_o      (mmio_load_hit),
      .console_valid_o (console_valid_o),
      .console_data_o  (console_data_o),
      .test_done_o     (test_done_o)
   );
`else
   assign mmio_store_hit  = 1'b0;
   assign mmio_load_hit   = 1'b0;
   assign console_valid_o = 1'b0;
   assign console_data_o  = '0;
   assign test_done_o     = 1'b0;
`endif

   assign dm_ready_o  = ~starved & ~rst_i;
   assign ram_addr_o  = rst_i      ? '0 :
                        data_grant ? dm_addr_i[ADDR_WIDTH+1:2] : im_addr_i[ADDR_WIDTH+1:2];
   assign ram_wdata_o = rst_i ? '0 : dm_data_s_i;
   assign ram_we_o    = (store_grant & ~mmio_store_hit) ? dm_data_select_i : 4'b0000;

   // Store beats load when both are raised; a losing fetch bumps the starve count.
   always_comb begin
      resp_d   = RESP_FETCH;
      starve_d = '0;
      if (data_grant) begin
         starve_d = starve_q + CW'(1);
         if (dm_store_i)
            resp_d = RESP_STORE;
         else if (mmio_load_hit)
            resp_d = RESP_MMIO;
         else
            resp_d = RESP_LOAD;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_q    <= RESP_NONE;
         starve_q  <= '0;
         im_data_q <= '0;
         dm_data_q <= '0;
      end else begin
         resp_q   <= resp_d;
         starve_q <= starve_d;
         if (resp_q == RESP_FETCH)
            im_data_q <= ram_rdata_i;
         if (resp_q == RESP_LOAD)
            dm_data_q <= ram_rdata_i;
         else if (resp_q == RESP_MMIO)
            dm_data_q <= '0;
      end
   end

   assign im_valid_o      = (resp_q == RESP_FETCH);
   assign im_data_o       = (resp_q == RESP_FETCH) ? ram_rdata_i : im_data_q;
   assign dm_load_done_o  = (resp_q == RESP_LOAD) | (resp_q == RESP_MMIO);
   assign dm_data_l_o     = (resp_q == RESP_LOAD) ? ram_rdata_i :
                            (resp_q == RESP_MMIO) ? 32'd0 : dm_data_q;
   assign dm_store_done_o = (resp_q == RESP_STORE);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_rv_mem_arbiter;

   localparam int AW    = 14;
   localparam int DEPTH = 1 << AW;
   localparam int SMAX  = 4;
`ifdef URV_MEM_ARB_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif

   localparam logic [31:0] WORD_A = 32'h1111_AAAA;
   localparam logic [31:0] WORD_B = 32'h2222_BBBB;
   localparam logic [31:0] WORD_C = 32'h3333_CCCC;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [31:0]   im_addr_i = '0;
   logic [31:0]   dm_addr_i = '0;
   logic [31:0]   dm_data_s_i = '0;
   logic [3:0]    dm_data_select_i = '0;
   logic          dm_store_i = 1'b0;
   logic          dm_load_i = 1'b0;
   logic [31:0]   im_data_o, dm_data_l_o, ram_wdata_o, ram_rdata_i;
   logic          im_valid_o, dm_ready_o, dm_load_done_o, dm_store_done_o;
   logic          console_valid_o, test_done_o;
   logic [7:0]    console_data_o;
   logic [AW-1:0] ram_addr_o;
   logic [3:0]    ram_we_o;

   always #5 clk_i = ~clk_i;

   rv_mem_arbiter #(.ADDR_WIDTH(AW), .FETCH_STARVE_MAX(SMAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .im_addr_i(im_addr_i), .im_data_o(im_data_o), .im_valid_o(im_valid_o),
      .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
      .dm_store_i(dm_store_i), .dm_load_i(dm_load_i), .dm_ready_o(dm_ready_o),
      .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_rdata_i(ram_rdata_i),
      .console_valid_o(console_valid_o), .console_data_o(console_data_o), .test_done_o(test_done_o)
   );

   function automatic logic [31:0] init_word(input int i);
      case (i)
         0:       return WORD_A;
         1:       return WORD_B;
         2:       return WORD_C;
         16:      return 32'hDEAD_BEEF;
         default: return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
      endcase
   endfunction

   function automatic logic [31:0] widx(input logic [31:0] a);
      return 32'(a[AW+1:2]);
   endfunction

   // Synchronous single-port RAM, 1-cycle read latency, byte write enables.
   logic [31:0] ram [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
      ram_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         ram_rdata_i <= ram[ram_addr_o];
         for (int b = 0; b < 4; b++)
            if (ram_we_o[b]) ram[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [DEPTH];
   int          denied;
   logic        exp_im_valid, exp_ld_done, exp_st_done, exp_con_valid, exp_td;
   logic [31:0] exp_im_data, exp_ld_data;
   logic [7:0]  exp_con_data;
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   logic        last_ready, last_ld_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
   endtask

   task automatic model_reset();
      denied        = 0;
      exp_im_valid  = 1'b0;
      exp_ld_done   = 1'b0;
      exp_st_done   = 1'b0;
      exp_con_valid = 1'b0;
      exp_td        = 1'b0;
      exp_im_data   = '0;
      exp_ld_data   = '0;
      exp_con_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      dm_load_i = 1'b0;
      dm_store_i = 1'b0;
      @(negedge clk_i);
      #1;
      check_eq("rst_im_valid", 32'(im_valid_o), 32'd0);
      check_eq("rst_im_data", im_data_o, 32'd0);
      check_eq("rst_ld_done", 32'(dm_load_done_o), 32'd0);
      check_eq("rst_ld_data", dm_data_l_o, 32'd0);
      check_eq("rst_st_done", 32'(dm_store_done_o), 32'd0);
      check_eq("rst_ram_we", 32'(ram_we_o), 32'd0);
      check_eq("rst_ready", 32'(dm_ready_o), 32'd0);
      check_eq("rst_con", 32'({console_valid_o, test_done_o, console_data_o}), 32'd0);
      model_reset();
      $display("cyc %0d reset applied", cyc);
   endtask

   // One clock cycle: drive request, check last cycle's response and this cycle's grant, advance model.
   task automatic step(input logic [31:0] ia, input logic ld, input logic st,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] sel);
      logic data_wins, in_mmio, is_con, is_td;
      logic [31:0] idx;
      @(negedge clk_i);
      rst_i = 1'b0;
      im_addr_i = ia; dm_load_i = ld; dm_store_i = st;
      dm_addr_i = da; dm_data_s_i = wd; dm_data_select_i = sel;
      #1;
      cyc++;
      check_eq("im_valid", 32'(im_valid_o), 32'(exp_im_valid));
      check_eq("im_data", im_data_o, exp_im_data);
      check_eq("ld_done", 32'(dm_load_done_o), 32'(exp_ld_done));
      check_eq("ld_data", dm_data_l_o, exp_ld_data);
      check_eq("st_done", 32'(dm_store_done_o), 32'(exp_st_done));
      check_eq("con_valid", 32'(console_valid_o), 32'(exp_con_valid));
      check_eq("con_data", 32'(console_data_o), 32'(exp_con_data));
      check_eq("test_done", 32'(test_done_o), 32'(exp_td));
      last_ready   = dm_ready_o;
      last_ld_done = dm_load_done_o;

      data_wins = (ld || st) && (denied < SMAX);
      in_mmio   = MMIO_EN && (da[31:3] == 29'h0002_0000);
      is_con    = in_mmio && !da[2];
      is_td     = in_mmio && da[2];
      check_eq("dm_ready", 32'(dm_ready_o), 32'(denied < SMAX));
      check_eq("ram_we", 32'(ram_we_o), (data_wins && st && !in_mmio) ? 32'(sel) : 32'd0);
      if (!data_wins)
         check_eq("ram_addr_f", 32'(ram_addr_o), widx(ia));
      else if (!in_mmio)
         check_eq("ram_addr_d", 32'(ram_addr_o), widx(da));

      $display("cyc %0d %s ia=%h da=%h wd=%h sel=%b ready=%0d", cyc,
               !data_wins ? "fetch" : (st ? "store" : "load "), ia, da, wd, sel, dm_ready_o);

      exp_im_valid  = !data_wins;
      exp_st_done   = data_wins && st;
      exp_ld_done   = data_wins && !st;
      exp_con_valid = data_wins && st && is_con;
      exp_td        = data_wins && st && is_td;
      if (exp_con_valid) exp_con_data = wd[7:0];
      if (!data_wins) exp_im_data = ref_mem[widx(ia)];
      if (exp_ld_done) exp_ld_data = in_mmio ? 32'd0 : ref_mem[widx(da)];
      if (exp_st_done && !in_mmio) begin
         idx = widx(da);
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
      end
      denied = data_wins ? denied + 1 : 0;
   endtask

   task automatic idle(input logic [31:0] ia);
      step(ia, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
   endtask

   logic ready_hist [1:10];
   int   pulses;

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      model_reset();
      do_reset();

      // Fetch stream
      idle(32'h0);
      idle(32'h4);
      check_eq("t1_A", im_data_o, WORD_A);
      idle(32'h8);
      check_eq("t1_B", im_data_o, WORD_B);
      idle(32'hC);
      check_eq("t1_C", im_data_o, WORD_C);

      // Load, byte store, wrap-around load
      step(32'h10, 1'b1, 1'b0, 32'h40, 32'd0, 4'b0000);
      idle(32'h10);
      check_eq("t2_done", 32'(dm_load_done_o), 32'd1);
      check_eq("t2_data", dm_data_l_o, 32'hDEAD_BEEF);
      check_eq("t2_noimv", 32'(im_valid_o), 32'd0);
      step(32'h14, 1'b0, 1'b1, 32'h40, 32'h0000_00AA, 4'b0001);
      idle(32'h14);
      check_eq("t3_done", 32'(dm_store_done_o), 32'd1);
      idle(32'h18);
      check_eq("t3_ram", ram[16], 32'hDEAD_BEAA);
      step(32'h1C, 1'b1, 1'b0, 32'h0001_0000, 32'd0, 4'b0000);
      idle(32'h1C);
      check_eq("t5_wrap", dm_data_l_o, WORD_A);

      // Reset while a load response is pending
      step(32'h20, 1'b1, 1'b0, 32'h40, 32'd0, 4'b0000);
      do_reset();
      idle(32'h20);
      check_eq("rst_no_ld", 32'(dm_load_done_o), 32'd0);

      // Starvation: load held for 10 cycles
      do_reset();
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         step(32'h24, 1'b1, 1'b0, 32'h80, 32'd0, 4'b0000);
         ready_hist[k] = last_ready;
         if (k <= 8 && last_ld_done) pulses++;
      end
      check_eq("t4_rdy4", 32'(ready_hist[4]), 32'd1);
      check_eq("t4_rdy5", 32'(ready_hist[5]), 32'd0);
      check_eq("t4_rdy10", 32'(ready_hist[10]), 32'd0);
      check_eq("t4_pulses", 32'(pulses), 32'd6);
      idle(32'h28);

`ifdef URV_MEM_ARB_MMIO_EN
      step(32'h2C, 1'b0, 1'b1, 32'h0010_0000, 32'h0000_0048, 4'b0001);
      step(32'h2C, 1'b0, 1'b1, 32'h0010_0004, 32'h0000_0001, 4'b1111);
      check_eq("t6_con_v", 32'(console_valid_o), 32'd1);
      check_eq("t6_con_d", 32'(console_data_o), 32'h48);
      step(32'h2C, 1'b1, 1'b0, 32'h0010_0000, 32'd0, 4'b0000);
      check_eq("t6_done", 32'(test_done_o), 32'd1);
      idle(32'h30);
      check_eq("t6_ld0", dm_data_l_o, 32'd0);
      check_eq("t6_ram0", ram[0], WORD_A);
`endif

      // Random traffic, including occasional simultaneous load+store
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [31:0] ra, rd;
         r  = int'($urandom_range(0, 9));
         ra = (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 31)) << 2)
              | 32'($urandom_range(0, 3));
         rd = $urandom;
         step($urandom, (r < 4) || (r == 9), (r >= 4 && r < 7) || (r == 9),
              ra, rd, 4'($urandom_range(0, 15)));
      end
      idle(32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
